// File: rtl/enc8b10b_pkg.sv
// Shared 8b/10b definitions: symbol width, K28.5 idle commas and the
// disparity classification returned by disparity_class_10b.
package enc8b10b_pkg;

  localparam int unsigned SYM_W = 10;

  localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0011111010;
  localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic [1:0] {
    DISP_NEUTRAL,
    DISP_POS,
    DISP_NEG,
    DISP_INVALID
  } disp_t;

endpackage

// File: rtl/disparity_class_10b.sv
// Classifies a 10-bit code group by popcount: 5 neutral, 6 positive,
// 4 negative, anything else invalid.
module disparity_class_10b
  import enc8b10b_pkg::*;
(
  input  logic [SYM_W-1:0] sym,
  output disp_t            disp
);

  logic [3:0] ones;

  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < SYM_W; i++) begin
      ones = ones + {3'b000, sym[i]};
    end
    case (ones)
      4'd5:    disp = DISP_NEUTRAL;
      4'd6:    disp = DISP_POS;
      4'd4:    disp = DISP_NEG;
      default: disp = DISP_INVALID;
    endcase
  end

endmodule

// File: rtl/tx_disparity_serializer.sv
// 10-bit symbol serializer with a one-entry skid buffer, running-disparity
// tracking fed back to the encoder, and K28.5 idle insertion on underrun.
module tx_disparity_serializer
  import enc8b10b_pkg::*;
#(
  parameter logic RD_INIT    = 1'b0,
  parameter int   DISP_CHECK = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [SYM_W-1:0] S_DATA,
  input  logic             S_VALID,
  output logic             S_READY,
  output logic             RD,
  output logic             TX,
  output logic             LOAD,
  output logic             UNDERRUN,
  output logic             DISP_ERR
);

  localparam logic [3:0] CNT_LAST = 4'd9;

  logic [SYM_W-1:0] shr;
  logic [SYM_W-1:0] hold;
  logic             hv;
  logic [3:0]       cnt;
  logic             rd;

  disp_t            in_disp;
  logic             xfer;
  logic             rd_next;
  logic             err_now;

  disparity_class_10b u_class (
    .sym  (S_DATA),
    .disp (in_disp)
  );

  assign S_READY = !hv;
  assign TX      = shr[SYM_W-1];
  assign RD      = rd;
  assign xfer    = S_VALID && S_READY;

  // RD is updated when a symbol is accepted, not when it is loaded; with a
  // single in-order buffer this still tracks transmit order.
  always_comb begin
    rd_next = rd;
    err_now = 1'b0;
    case (in_disp)
      DISP_POS: begin
        rd_next = 1'b1;
        err_now = rd;
      end
      DISP_NEG: begin
        rd_next = 1'b0;
        err_now = !rd;
      end
      DISP_INVALID: err_now = 1'b1;
      default: ;
    endcase
    if (DISP_CHECK == 0) err_now = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shr      <= '0;
      hold     <= '0;
      hv       <= 1'b0;
      cnt      <= CNT_LAST;
      rd       <= RD_INIT;
      LOAD     <= 1'b0;
      UNDERRUN <= 1'b0;
      DISP_ERR <= 1'b0;
    end else begin
      LOAD     <= 1'b0;
      UNDERRUN <= 1'b0;
      DISP_ERR <= 1'b0;
      if (xfer) begin
        rd       <= rd_next;
        DISP_ERR <= err_now;
      end
      if (cnt == CNT_LAST) begin
        cnt  <= '0;
        LOAD <= 1'b1;
        if (hv) begin
          shr <= hold;
          hv  <= 1'b0;
        end else if (S_VALID) begin
          shr <= S_DATA;
        end else begin
          shr      <= rd ? K28_5_RDP : K28_5_RDN;
          rd       <= !rd;
          UNDERRUN <= 1'b1;
        end
      end else begin
        shr <= {shr[SYM_W-2:0], 1'b0};
        cnt <= cnt + 4'd1;
        if (xfer) begin
          hold <= S_DATA;
          hv   <= 1'b1;
        end
      end
    end
  end

endmodule
